// File: rtl/simple_adder_8bit.sv
`default_nettype none
// ============================================================================
// Module      : simple_adder_8bit
// Description : Unsigned ripple-carry adder with carry-in/carry-out and signed
//               overflow flag. Combinational result plus a registered copy
//               qualified by in_valid/out_valid for pipelined consumers.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_adder_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    // Carry chain: w_carry[i] is the carry into bit i, w_carry[WIDTH] is the
    // carry out of the MSB.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum_q;
    logic             r_cout_q;
    logic             r_ovf_q;
    logic             r_out_valid;

    assign w_carry[0] = cin;

    // One full adder per bit; plain gates so X inputs propagate unmasked.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic w_p;
            assign w_p            = a[i] ^ b[i];
            assign w_sum[i]       = w_p ^ w_carry[i];
            assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & w_p);
        end
    endgenerate

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign w_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];

    assign sum  = w_sum;
    assign cout = w_carry[WIDTH];
    assign ovf  = w_ovf;

    // Capture the combinational result on in_valid; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_q     <= '0;
            r_cout_q    <= 1'b0;
            r_ovf_q     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum_q  <= w_sum;
                r_cout_q <= w_carry[WIDTH];
                r_ovf_q  <= w_ovf;
            end
        end
    end

    assign sum_q     = r_sum_q;
    assign cout_q    = r_cout_q;
    assign ovf_q     = r_ovf_q;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_simple_adder_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_adder_8bit
// Description : Self-checking bench for simple_adder_8bit: directed vectors
//               with hand-computed results, reset/capture interaction, and a
//               random sweep against a reference sum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_adder_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       in_valid;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic [7:0] sum_q;
    logic       cout_q;
    logic       ovf_q;
    logic       out_valid;

    int n_checks;
    int n_fail;

    // Reference registered state for the random sweep
    logic [7:0] exp_sum_q;
    logic       exp_cout_q;
    logic       exp_ovf_q;
    logic       exp_valid;

    simple_adder_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .ovf_q     (ovf_q),
        .out_valid (out_valid)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports any mismatch
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] ref_full;
        logic       ref_ovf;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        a        = 8'd0;
        b        = 8'd0;
        cin      = 1'b0;
        in_valid = 1'b0;

        // 1: zero operands
        #10;
        check("zero_sum", 32'(sum), 32'd0);
        check("zero_cout", 32'(cout), 32'd0);
        check("zero_ovf", 32'(ovf), 32'd0);

        // 2: 255+0, then carry-in wraps to 0
        a = 8'd255; b = 8'd0; cin = 1'b0; #1;
        check("max_sum", 32'(sum), 32'd255);
        check("max_cout", 32'(cout), 32'd0);
        cin = 1'b1; #1;
        check("wrap_sum", 32'(sum), 32'd0);
        check("wrap_cout", 32'(cout), 32'd1);

        // 255+255+1 -> 511
        b = 8'd255; #1;
        check("full_sum", 32'(sum), 32'd255);
        check("full_cout", 32'(cout), 32'd1);

        // 3: -128 + -128 overflows
        a = 8'd128; b = 8'd128; cin = 1'b0; #1;
        check("neg_ovf_sum", 32'(sum), 32'd0);
        check("neg_ovf_cout", 32'(cout), 32'd1);
        check("neg_ovf_ovf", 32'(ovf), 32'd1);

        // 127+1 positive overflow
        a = 8'd127; b = 8'd1; #1;
        check("pos_ovf_sum", 32'(sum), 32'd128);
        check("pos_ovf_ovf", 32'(ovf), 32'd1);
        check("pos_ovf_cout", 32'(cout), 32'd0);

        // 4: 100+150+1 = 251
        a = 8'd100; b = 8'd150; cin = 1'b1; #1;
        check("mix_sum", 32'(sum), 32'd251);
        check("mix_cout", 32'(cout), 32'd0);
        check("mix_ovf", 32'(ovf), 32'd0);

        // 5: reset for two edges
        tick();
        tick();
        check("rst_sum_q", 32'(sum_q), 32'd0);
        check("rst_cout_q", 32'(cout_q), 32'd0);
        check("rst_ovf_q", 32'(ovf_q), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);

        // Capture 200+100 = 300 -> 44, cout 1, no signed overflow (-56+100)
        rst = 1'b0; a = 8'd200; b = 8'd100; cin = 1'b0; in_valid = 1'b1;
        tick();
        check("cap_sum_q", 32'(sum_q), 32'd44);
        check("cap_cout_q", 32'(cout_q), 32'd1);
        check("cap_ovf_q", 32'(ovf_q), 32'd0);
        check("cap_valid", 32'(out_valid), 32'd1);

        // Hold with in_valid low even though operands change
        in_valid = 1'b0; a = 8'd1; b = 8'd1;
        tick();
        check("hold_valid", 32'(out_valid), 32'd0);
        check("hold_sum_q", 32'(sum_q), 32'd44);
        check("hold_cout_q", 32'(cout_q), 32'd1);

        // 6: capture and reset at the same edge -> reset wins
        in_valid = 1'b1; rst = 1'b1; a = 8'd10; b = 8'd20;
        tick();
        check("rstcap_sum_q", 32'(sum_q), 32'd0);
        check("rstcap_valid", 32'(out_valid), 32'd0);
        check("rstcap_cout_q", 32'(cout_q), 32'd0);

        // Back-to-back captures: 10+20=30, 128+128=0/c/o, 5+6+1=12
        rst = 1'b0; a = 8'd10; b = 8'd20; cin = 1'b0;
        tick();
        check("b2b0_sum_q", 32'(sum_q), 32'd30);
        check("b2b0_valid", 32'(out_valid), 32'd1);
        a = 8'd128; b = 8'd128;
        tick();
        check("b2b1_sum_q", 32'(sum_q), 32'd0);
        check("b2b1_cout_q", 32'(cout_q), 32'd1);
        check("b2b1_ovf_q", 32'(ovf_q), 32'd1);
        check("b2b1_valid", 32'(out_valid), 32'd1);
        a = 8'd5; b = 8'd6; cin = 1'b1;
        tick();
        check("b2b2_sum_q", 32'(sum_q), 32'd12);
        check("b2b2_ovf_q", 32'(ovf_q), 32'd0);
        check("b2b2_valid", 32'(out_valid), 32'd1);

        // Random sweep with random capture strobes
        exp_sum_q  = 8'd12;
        exp_cout_q = 1'b0;
        exp_ovf_q  = 1'b0;
        exp_valid  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a        = 8'($urandom_range(255, 0));
            b        = 8'($urandom_range(255, 0));
            cin      = 1'($urandom_range(1, 0));
            in_valid = 1'($urandom_range(1, 0));
            #1;
            ref_full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            ref_ovf  = (a[7] == b[7]) && (ref_full[7] != a[7]);
            check("rnd_sum", 32'(sum), 32'(ref_full[7:0]));
            check("rnd_cout", 32'(cout), 32'(ref_full[8]));
            check("rnd_ovf", 32'(ovf), 32'(ref_ovf));
            if (in_valid) begin
                exp_sum_q  = ref_full[7:0];
                exp_cout_q = ref_full[8];
                exp_ovf_q  = ref_ovf;
            end
            exp_valid = in_valid;
            tick();
            check("rnd_sum_q", 32'(sum_q), 32'(exp_sum_q));
            check("rnd_cout_q", 32'(cout_q), 32'(exp_cout_q));
            check("rnd_ovf_q", 32'(ovf_q), 32'(exp_ovf_q));
            check("rnd_valid", 32'(out_valid), 32'(exp_valid));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
